// File: rtl/sha256_hash_ctrl.sv
// Sequencer for the SHA-256 compression datapath: H-word load, round streaming,
// hash-computed handshake with timeout, result send and completion pulse.
module sha256_hash_ctrl #(
  parameter int NUMBER_OF_Hs     = 8,
  parameter int NUMBER_OF_ROUNDS = 64,
  parameter int OUTPUT_LENGTH    = 8,
  parameter int READ_LAT         = 2,
  parameter int DONE_TIMEOUT     = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                xxx__dut__go,
  output logic                                dut__xxx__finish,
  output logic                                dut__xxx__busy,
  output logic                                dut__xxx__error,
  output logic [$clog2(NUMBER_OF_Hs)-1:0]     dut__hmem__address,
  output logic                                dut__hmem__enable,
  output logic [$clog2(NUMBER_OF_ROUNDS)-1:0] dut__kmem__address,
  output logic                                dut__kmem__enable,
  output logic [$clog2(NUMBER_OF_ROUNDS)-1:0] dut__wmem__address,
  output logic                                dut__wmem__enable,
  output logic                                trigger,
  output logic                                trigger_w,
  output logic                                trigger_dom_send,
  input  logic                                hash_computed,
  output logic [$clog2(NUMBER_OF_ROUNDS)-1:0] round
);
  localparam int HAW = $clog2(NUMBER_OF_Hs);
  localparam int KAW = $clog2(NUMBER_OF_ROUNDS);
  localparam int TAW = $clog2(DONE_TIMEOUT + 1);
  localparam int SAW = $clog2(OUTPUT_LENGTH + 1);
  localparam logic [HAW-1:0] H_LAST = HAW'(NUMBER_OF_Hs - 1);
  localparam logic [KAW-1:0] K_LAST = KAW'(NUMBER_OF_ROUNDS - 1);
  localparam logic [TAW-1:0] T_LAST = TAW'(DONE_TIMEOUT - 1);
  localparam logic [SAW-1:0] S_LAST = SAW'(OUTPUT_LENGTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_H, S_ROUNDS, S_WAIT_HASH, S_SEND, S_DONE
  } state_e;

  state_e                      state_q, state_d;
  logic                        h_en_q, h_en_d;
  logic [HAW-1:0]              h_addr_q, h_addr_d;
  logic                        kw_en_q, kw_en_d;
  logic [KAW-1:0]              kw_addr_q, kw_addr_d;
  logic [TAW-1:0]              wait_cnt_q, wait_cnt_d;
  logic [SAW-1:0]              send_cnt_q, send_cnt_d;
  logic                        error_q, error_d;
  logic [READ_LAT-1:0]         h_sr_q, kw_sr_q;
  logic [READ_LAT-1:0][KAW-1:0] round_sr_q;

  // Bit 0 is the enable at issue; bit READ_LAT is the enable as seen by the datapath.
  logic [READ_LAT:0]           h_chain, kw_chain;
  logic [READ_LAT:0][KAW-1:0]  round_chain;
  logic                        h_last_trig, kw_last_trig;

  assign h_chain     = {h_sr_q, h_en_q};
  assign kw_chain    = {kw_sr_q, kw_en_q};
  assign round_chain = {round_sr_q, kw_addr_q};

  // Last strobe cycle: strobe high with nothing left in flight behind it.
  assign h_last_trig  = h_chain[READ_LAT] & ~(|h_chain[READ_LAT-1:0]);
  assign kw_last_trig = kw_chain[READ_LAT] & ~(|kw_chain[READ_LAT-1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      h_en_q     <= 1'b0;
      h_addr_q   <= '0;
      kw_en_q    <= 1'b0;
      kw_addr_q  <= '0;
      wait_cnt_q <= '0;
      send_cnt_q <= '0;
      error_q    <= 1'b0;
      h_sr_q     <= '0;
      kw_sr_q    <= '0;
      round_sr_q <= '0;
    end else begin
      state_q    <= state_d;
      h_en_q     <= h_en_d;
      h_addr_q   <= h_addr_d;
      kw_en_q    <= kw_en_d;
      kw_addr_q  <= kw_addr_d;
      wait_cnt_q <= wait_cnt_d;
      send_cnt_q <= send_cnt_d;
      error_q    <= error_d;
      h_sr_q     <= h_chain[READ_LAT-1:0];
      kw_sr_q    <= kw_chain[READ_LAT-1:0];
      round_sr_q <= round_chain[READ_LAT-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    h_en_d     = h_en_q;
    h_addr_d   = h_addr_q;
    kw_en_d    = kw_en_q;
    kw_addr_d  = kw_addr_q;
    wait_cnt_d = wait_cnt_q;
    send_cnt_d = send_cnt_q;
    error_d    = error_q;
    case (state_q)
      S_IDLE: begin
        if (xxx__dut__go) begin
          state_d    = S_LOAD_H;
          h_en_d     = 1'b1;
          h_addr_d   = '0;
          wait_cnt_d = '0;
          send_cnt_d = '0;
          error_d    = 1'b0;
        end
      end
      S_LOAD_H: begin
        if (h_en_q) begin
          if (h_addr_q == H_LAST) h_en_d = 1'b0;
          else                    h_addr_d = h_addr_q + 1'b1;
        end
        if (h_last_trig) begin
          state_d   = S_ROUNDS;
          kw_en_d   = 1'b1;
          kw_addr_d = '0;
        end
      end
      S_ROUNDS: begin
        if (kw_en_q) begin
          if (kw_addr_q == K_LAST) kw_en_d = 1'b0;
          else                     kw_addr_d = kw_addr_q + 1'b1;
        end
        if (kw_last_trig) begin
          state_d    = S_WAIT_HASH;
          wait_cnt_d = '0;
        end
      end
      S_WAIT_HASH: begin
        if (hash_computed) begin
          state_d    = S_SEND;
          send_cnt_d = '0;
        end else if (wait_cnt_q == T_LAST) begin
          state_d    = S_SEND;
          send_cnt_d = '0;
          error_d    = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_SEND: begin
        if (send_cnt_q == S_LAST) state_d = S_DONE;
        else                      send_cnt_d = send_cnt_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign dut__hmem__address = h_addr_q;
  assign dut__hmem__enable  = h_en_q;
  assign dut__kmem__address = kw_addr_q;
  assign dut__kmem__enable  = kw_en_q;
  assign dut__wmem__address = kw_addr_q;
  assign dut__wmem__enable  = kw_en_q;
  assign trigger            = h_chain[READ_LAT];
  assign trigger_w          = kw_chain[READ_LAT];
  assign round              = round_chain[READ_LAT];
  assign trigger_dom_send   = (state_q == S_SEND);
  assign dut__xxx__busy     = (state_q != S_IDLE);
  assign dut__xxx__finish   = (state_q == S_DONE);
  assign dut__xxx__error    = error_q;

endmodule

// File: doc/sha256_hash_ctrl.md
# sha256_hash_ctrl

Sequencer for the SHA-256 compression datapath. On a start pulse it fetches the eight initial hash words from H-memory and presents them to the datapath, streams the 64 round constants and schedule words from K-memory and W-memory with the round strobe, waits for the datapath's hash-computed flag, then drives the result-send strobe and reports completion to the top level. It owns all memory addressing and every datapath strobe; the datapath itself holds no sequencing.

## Interface
Parameters:
- NUMBER_OF_Hs, 8, initial hash words loaded per block
- NUMBER_OF_ROUNDS, 64, compression rounds per block
- OUTPUT_LENGTH, 8, digest words written to output memory
- READ_LAT, 2, cycles from address issue to datapath-registered data (memory read plus datapath input register)
- DONE_TIMEOUT, 4, cycles to wait for hash_computed before flagging an error

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- xxx__dut__go  in  1  start pulse, sampled only in IDLE
- dut__xxx__finish  out  1  one-cycle pulse when the block is fully sent
- dut__xxx__busy  out  1  high in every state except IDLE
- dut__xxx__error  out  1  sticky; set on hash_computed timeout, cleared by reset or the next accepted go
- dut__hmem__address  out  $clog2(NUMBER_OF_Hs)  H-memory read address
- dut__hmem__enable  out  1  H-memory read enable
- dut__kmem__address  out  $clog2(NUMBER_OF_ROUNDS)  K-memory read address
- dut__kmem__enable  out  1  K-memory read enable
- dut__wmem__address  out  $clog2(NUMBER_OF_ROUNDS)  W-memory read address (same value as the K address)
- dut__wmem__enable  out  1  W-memory read enable
- trigger  out  1  datapath H-load strobe, one word per cycle
- trigger_w  out  1  datapath round strobe, one round per cycle
- trigger_dom_send  out  1  datapath result-send strobe
- hash_computed  in  1  datapath flag, high for one cycle after trigger_w falls
- round  out  $clog2(NUMBER_OF_ROUNDS)  index of the round whose operands trigger_w is currently qualifying

## Operation
- States: IDLE, LOAD_H, ROUNDS, WAIT_HASH, SEND, DONE.
- IDLE: all strobes and enables low. go=1 moves to LOAD_H, clears the issue counter and clears error. go in any other state is ignored.
- LOAD_H: issue hmem addresses 0..NUMBER_OF_Hs-1 on consecutive cycles with enable high. trigger is the enable delayed by READ_LAT cycles, so it is high for exactly NUMBER_OF_Hs contiguous cycles. Move to ROUNDS in the cycle after the last trigger.
- ROUNDS: issue k/w addresses 0..NUMBER_OF_ROUNDS-1 with both enables high. trigger_w is the enable delayed by READ_LAT cycles: exactly 64 contiguous high cycles. round equals the address delayed by READ_LAT. Move to WAIT_HASH in the cycle trigger_w falls.
- WAIT_HASH: hash_computed=1 moves to SEND. If hash_computed is not seen within DONE_TIMEOUT cycles, set error and move to SEND anyway.
- SEND: hold trigger_dom_send high for OUTPUT_LENGTH+1 consecutive cycles, which covers the datapath's write counter plus its terminal cycle. Then move to DONE.
- DONE: finish=1 for one cycle, then return to IDLE.
- Counters saturate and never wrap. Address outputs hold their last value while enables are low.
- hash_computed outside WAIT_HASH is ignored.

## Timing
- Reset: state IDLE. All outputs 0: addresses, enables, trigger, trigger_w, trigger_dom_send, busy, finish, error, round. The delay pipelines are also cleared.
- Reset asserted mid-operation wins in the same edge. Strobes in flight in the READ_LAT pipeline are flushed; no trigger or trigger_w pulse appears after reset.
- Latency for the nominal case (READ_LAT=2, hash_computed one cycle after trigger_w falls), counted in cycles from the go edge:
  - LOAD_H: 10 cycles
  - ROUNDS: 66 cycles
  - WAIT_HASH: 1 cycle
  - SEND: 9 cycles
  - DONE: 1 cycle
  - total: 87 cycles
- busy rises the cycle after go is sampled and falls the cycle after finish.
- go asserted in the same cycle as finish is ignored. A go held high continuously restarts in the first cycle of IDLE.
- trigger, trigger_w and trigger_dom_send are mutually exclusive in every cycle.

## Test plan
- Nominal block: go pulse with hmem loaded with the FIPS 180-4 IV, kmem/wmem loaded for message "abc" -> trigger high 8 cycles, trigger_w high 64 cycles, round 0..63, trigger_dom_send high 9 cycles, finish at cycle 87, output memory holds ba7816bf...f20015ad.
- Address check: monitor the address ports -> hmem 0..7 each exactly once, kmem/wmem 0..63 in order, each trigger exactly READ_LAT cycles after its address.
- Timeout: hash_computed tied to 0 -> error set 4 cycles after trigger_w falls, SEND still runs, finish pulses. The next go clears error.
- Reset mid-ROUNDS: reset asserted at round 30 -> next cycle all outputs 0, no residual trigger_w. A fresh go then completes a correct digest.
- go abuse: go pulses during LOAD_H, ROUNDS and SEND, and go coincident with finish -> no restart, no change to the sequence. go held high -> back-to-back blocks separated by exactly one IDLE cycle.
- Exclusivity: assert on every cycle that at most one of trigger, trigger_w and trigger_dom_send is high, and that busy=0 only in IDLE.
